// File: rtl/tft_spi_arbiter.sv
// Purpose : arbitrates N_REQ panel-command requesters onto one shared SPI byte transmitter.
// Latency : grant one edge after an eligible request in IDLE (two edges minimum after reset); mux path is combinational.
// Backpressure: spi_busy is reflected to the owner on req_busy and holds DRAIN; non-owners always see busy=1.
//
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   req/req_data/req_dc       per-requester level request, byte and data/command flag
//   req_transmit              per-requester one-cycle transmit pulse
//   init_done                 unmasks requesters 1..N_REQ-1 for new selection
//   spi_busy                  busy from the shared transmitter
//   spi_data/spi_dc/spi_transmit  owner's stream to the transmitter
//   grant                     one-hot current owner (or zero)
//   req_busy                  per-requester busy view
//   timeout                   one-cycle pulse when a silent owner is revoked
module tft_spi_arbiter #(
  parameter int N_REQ        = 3,
  parameter int IDLE_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_dc,
  input  logic [N_REQ-1:0]   req_transmit,
  input  logic               init_done,
  input  logic               spi_busy,
  output logic [7:0]         spi_data,
  output logic               spi_dc,
  output logic               spi_transmit,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   req_busy,
  output logic               timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [N_REQ-1:0] lock_q, lock_d;
  // Low for the first edge after reset release so no grant lands on that edge.
  logic             armed_q;

  logic [N_REQ-1:0] elig;
  logic             found;
  logic [IW-1:0]    pick;
  int               idx;

  // Requester 0 has absolute priority; 1..N_REQ-1 rotate starting after
  // last_owner. last_owner=0 maps to a search starting at 1.
  always_comb begin
    elig  = req & ~lock_q;
    if (!init_done) elig = elig & {{(N_REQ-1){1'b0}}, 1'b1};
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    if (elig[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ-1; k++) begin
        idx = ((int'(last_q) + k) % (N_REQ-1)) + 1;
        if (!found && elig[idx]) begin
          found = 1'b1;
          pick  = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    // A lockout clears once its requester has been seen with req low.
    lock_d    = lock_q & req;
    case (state_q)
      IDLE: begin
        if (armed_q && found) begin
          state_d       = OWN;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          cnt_d         = '0;
          if (pick != '0) last_d = pick;
        end
      end
      OWN: begin
        if (cnt_q == CNT_MAX) begin
          state_d          = DRAIN;
          timeout_d        = 1'b1;
          lock_d[owner_q]  = 1'b1;
        end else if (!req[owner_q]) begin
          state_d = DRAIN;
        end else if (req_transmit[owner_q] || spi_busy) begin
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (!spi_busy) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      lock_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      lock_q    <= lock_d;
      armed_q   <= 1'b1;
    end
  end

  // Output mux is purely combinational from registered ownership, so reset
  // forces every output to its idle value without a clock.
  always_comb begin
    spi_data     = 8'h00;
    spi_dc       = 1'b0;
    spi_transmit = 1'b0;
    if (|grant_q) begin
      spi_data = req_data[8*owner_q +: 8];
      spi_dc   = req_dc[owner_q];
    end
    if (state_q == OWN) spi_transmit = req_transmit[owner_q];
    for (int i = 0; i < N_REQ; i++) req_busy[i] = grant_q[i] ? spi_busy : 1'b1;
  end

  assign grant   = grant_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_tft_spi_arbiter.sv
module tb_tft_spi_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req_dc, req_transmit;
  logic [8*N-1:0] req_data;
  logic           init_done, spi_busy;
  logic [7:0]     spi_data;
  logic           spi_dc, spi_transmit, timeout;
  logic [N-1:0]   grant, req_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tft_spi_arbiter #(.N_REQ(N), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_dc(req_dc),
    .req_transmit(req_transmit), .init_done(init_done), .spi_busy(spi_busy),
    .spi_data(spi_data), .spi_dc(spi_dc), .spi_transmit(spi_transmit),
    .grant(grant), .req_busy(req_busy), .timeout(timeout)
  );

  // Reference model: who owns the bus, whether it is draining, how many
  // silent cycles have passed, who is locked out, and the rotation pointer.
  int m_owner;
  int m_last;
  int m_idle;
  bit m_drain;
  bit m_armed;
  bit m_tpulse;
  bit m_locked [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_last   = 0;
    m_idle   = 0;
    m_drain  = 0;
    m_armed  = 0;
    m_tpulse = 0;
    for (int i = 0; i < N; i++) m_locked[i] = 0;
  endtask

  // Called right after a negedge with inputs already driven: checks outputs
  // against the model, advances the model across the next posedge, and
  // returns on the following negedge.
  task automatic step(input string tag);
    logic [N-1:0] eg, eb;
    logic [7:0]   ed;
    logic         edc, etx;
    int           cand, idx, who;
    bit           fire;
    #1;
    eg = '0; eb = '1; ed = 8'h00; edc = 1'b0; etx = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      eb[m_owner] = spi_busy;
      ed  = req_data[8*m_owner +: 8];
      edc = req_dc[m_owner];
      etx = !m_drain && req_transmit[m_owner];
    end
    chk({tag, ".grant"},    grant,        eg);
    chk({tag, ".spi_data"}, spi_data,     ed);
    chk({tag, ".spi_dc"},   spi_dc,       edc);
    chk({tag, ".spi_tx"},   spi_transmit, etx);
    chk({tag, ".req_busy"}, req_busy,     eb);
    chk({tag, ".timeout"},  timeout,      m_tpulse);

    fire = 0;
    who  = 0;
    if (m_owner < 0) begin
      if (m_armed) begin
        cand = -1;
        if (req[0] && !m_locked[0]) cand = 0;
        else if (init_done) begin
          idx = m_last;
          for (int k = 1; k < N; k++) begin
            idx = (idx == N-1) ? 1 : idx + 1;
            if (cand < 0 && req[idx] && !m_locked[idx]) cand = idx;
          end
        end
        if (cand >= 0) begin
          m_owner = cand;
          m_drain = 0;
          m_idle  = 0;
          if (cand > 0) m_last = cand;
        end
      end
    end else if (!m_drain) begin
      if (m_idle == TO) begin
        fire = 1; who = m_owner; m_drain = 1;
      end else if (!req[m_owner]) m_drain = 1;
      else if (req_transmit[m_owner] || spi_busy) m_idle = 0;
      else m_idle = m_idle + 1;
    end else if (!spi_busy) begin
      m_owner = -1;
      m_drain = 0;
    end
    for (int i = 0; i < N; i++) if (!req[i]) m_locked[i] = 0;
    if (fire) m_locked[who] = 1;
    m_tpulse = fire;
    m_armed  = 1;
    @(negedge clk);
  endtask

  task automatic send_bytes(input int o, input int n);
    for (int j = 0; j < n; j++) begin
      req_transmit[o]    = 1'b1;
      req_data[8*o +: 8] = 8'($urandom);
      req_dc[o]          = 1'($urandom_range(1));
      step("byte");
      req_transmit = '0;
      spi_busy     = 1'b1;
      step("busy");
      step("busy");
      spi_busy = 1'b0;
    end
  endtask

  initial begin
    logic [N-1:0] exp_g;
    int           n;
    rst = 1'b0; req = '0; req_dc = '1; req_transmit = '1; req_data = 24'hFFFFFF;
    init_done = 1'b0; spi_busy = 1'b1;
    model_reset();

    // Reset state with every input active.
    #3;
    chk("rst.grant",    grant,        3'b000);
    chk("rst.spi_tx",   spi_transmit, 1'b0);
    chk("rst.spi_data", spi_data,     8'h00);
    chk("rst.spi_dc",   spi_dc,       1'b0);
    chk("rst.req_busy", req_busy,     3'b111);
    chk("rst.timeout",  timeout,      1'b0);

    @(negedge clk);
    req_transmit = '0; req_dc = '0; req_data = '0; spi_busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // No grant on the first edge after release; requester 0 wins on the second.
    req = 3'b111;
    step("r031");
    chk("r031.no_grant", grant, 3'b000);
    step("r032a");
    chk("r032.g0", grant, 3'b001);
    req = 3'b110;
    step("r032b");
    chk("r032.drain_hold", grant, 3'b001);
    step("r032c");
    chk("r032.idle", grant, 3'b000);
    step("r032d");
    chk("r032.masked", grant, 3'b000);
    init_done = 1'b1;
    step("r032e");
    chk("r032.g1", grant, 3'b010);

    // Alternating bursts of 4 bytes between requesters 1 and 2.
    for (int b = 0; b < 4; b++) begin
      int o;
      o = (b % 2 == 0) ? 1 : 2;
      exp_g = '0; exp_g[o] = 1'b1;
      chk("r033.order", grant, exp_g);
      send_bytes(o, 4);
      req[o] = 1'b0;
      step("r033drop");
      step("r033drain");
      chk("r033.gap", grant, 3'b000);
      req[o] = 1'b1;
      step("r033next");
    end

    // Owner 1 drops req while the transmitter stays busy 9 cycles.
    spi_busy = 1'b1;
    req[1]   = 1'b0;
    step("r034a");
    chk("r034.hold0", grant, 3'b010);
    for (int j = 0; j < 8; j++) begin
      step("r034b");
      chk("r034.hold", grant, 3'b010);
    end
    spi_busy = 1'b0;
    step("r034c");
    chk("r034.clear", grant, 3'b000);

    // Silent owner 2 is revoked and locked out until it toggles req.
    step("r035a");
    chk("r035.grant", grant, 3'b100);
    n = 0;
    while (timeout !== 1'b1 && n < 20) begin
      step("r035wait");
      n++;
    end
    chk("r035.cycles", n, 9);
    chk("r035.drain", grant, 3'b100);
    step("r035b");
    chk("r035.pulse_end", timeout, 1'b0);
    chk("r035.revoked", grant, 3'b000);
    for (int j = 0; j < 3; j++) begin
      step("r035lock");
      chk("r035.locked", grant, 3'b000);
    end
    req[2] = 1'b0;
    step("r035c");
    req[2] = 1'b1;
    step("r035d");
    chk("r035.regrant", grant, 3'b100);

    // Non-owner pulse is ignored.
    req[2] = 1'b0;
    step("r036a");
    step("r036b");
    req[1] = 1'b1;
    step("r036c");
    chk("r036.grant", grant, 3'b010);
    req_transmit = 3'b110;
    req_data     = {8'hA5, 8'h2C, 8'h00};
    #1;
    chk("r036.tx",    spi_transmit, 1'b1);
    chk("r036.data",  spi_data,     8'h2C);
    chk("r036.busy2", req_busy[2],  1'b1);
    step("r036d");
    req_transmit = '0;

    // Asynchronous reset mid-burst, no clock edge in between.
    req_transmit[1] = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("r037.grant",    grant,        3'b000);
    chk("r037.spi_tx",   spi_transmit, 1'b0);
    chk("r037.spi_data", spi_data,     8'h00);
    chk("r037.req_busy", req_busy,     3'b111);
    model_reset();
    req = '0; req_transmit = '0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(9) == 0) req[i] = ~req[i];
      req_transmit = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) req_transmit[i] = 1'b1;
      spi_busy = ($urandom_range(4) == 0);
      if ($urandom_range(39) == 0) init_done = ~init_done;
      req_data = 24'($urandom);
      req_dc   = 3'($urandom);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tft_spi_arbiter.md
TFT_SPI_ARBITER -- requirements
Module: tft_spi_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): N_REQ, 3, number of requesters (2..8); IDLE_TIMEOUT, 1023, grant-holding cycles allowed without a transmit pulse before revocation.
REQ-002 Ports SHALL be (name direction width meaning): clk  input  1  system clock; rst  input  1  reset, asynchronous, active-low.
REQ-003 req  input  N_REQ  per-requester bus request; level, held for the whole burst.
REQ-004 req_data  input  8*N_REQ  byte for requester i at bits [8i+7:8i].
REQ-005 req_dc  input  N_REQ  data/command flag per requester.
REQ-006 req_transmit  input  N_REQ  one-cycle transmit pulse per requester.
REQ-007 init_done  input  1  panel initialization complete; unmasks requesters 1..N_REQ-1.
REQ-008 spi_busy  input  1  busy from the shared SPI transmitter.
REQ-009 spi_data  output  8, spi_dc  output  1, spi_transmit  output  1: muxed command stream to the transmitter.
REQ-010 grant  output  N_REQ  one-hot (or zero) current owner.
REQ-011 req_busy  output  N_REQ  per-requester busy view.
REQ-012 timeout  output  1  one-cycle pulse on grant revocation.

Function
REQ-013 Eligible set SHALL be req[0] always, and req[i] for i>=1 only while init_done=1.
REQ-014 FSM states SHALL be IDLE, OWN, DRAIN.
REQ-015 IDLE: if any eligible request, grant SHALL become one-hot on the next clock edge and state SHALL go to OWN; else remain IDLE with grant=0.
REQ-016 Selection SHALL be: requester 0 wins whenever eligible; otherwise round-robin among 1..N_REQ-1 starting at last_owner+1, wrapping from N_REQ-1 to 1.
REQ-017 last_owner SHALL update only when a requester index >=1 is granted; reset value 0, so after reset requester 1 is searched first.
REQ-018 spi_data, spi_dc SHALL equal the owner's req_data, req_dc combinationally; 8'h00 and 0 when grant=0.
REQ-019 spi_transmit SHALL equal req_transmit[owner] AND state==OWN, combinational, zero added latency; transmit pulses of non-owners SHALL be ignored and not queued.
REQ-020 req_busy[i] SHALL be spi_busy when grant[i]=1, else 1.
REQ-021 OWN: when req[owner] falls, state SHALL go to DRAIN on the next edge; grant is held.
REQ-022 DRAIN: grant held while spi_busy=1; on the first cycle spi_busy=0, grant SHALL clear and state return to IDLE; minimum one IDLE cycle between owners.
REQ-023 Preemption SHALL NOT occur: requester 0 raising req mid-burst waits until the current owner reaches IDLE.
REQ-024 Idle counter SHALL reset to 0 on entering OWN and on each owner transmit pulse or spi_busy=1 cycle, else increment by 1 in OWN.
REQ-025 Counter reaching IDLE_TIMEOUT SHALL force DRAIN on the next edge and pulse timeout for exactly one cycle; that requester SHALL be ineligible until it deasserts req for at least one cycle.
REQ-026 Counter width SHALL be clog2(IDLE_TIMEOUT+1) bits; it SHALL saturate, never wrap.
REQ-027 init_done falling while a requester >=1 owns SHALL NOT revoke; masking applies only to new selection.
REQ-028 Owner raising transmit while spi_busy=1 is a requester protocol violation; the pulse SHALL still pass through unchanged.

Reset
REQ-029 On rst=0, asynchronously: state=IDLE, grant=0, last_owner=0, counter=0, timeout=0, spi_transmit=0, spi_data=8'h00, spi_dc=0, req_busy=all ones, timeout-lockout flags cleared.
REQ-030 Reset asserted mid-burst SHALL drop the grant immediately; a partially sent byte is the transmitter's responsibility.
REQ-031 After rst rises, first grant SHALL occur no earlier than the second clock edge.

Verification
REQ-032 init_done=0, req=3'b111 -> grant=3'b001 one edge later; req[0] dropped, spi_busy=0 -> grant=0, then grant=3'b010 (1,2 masked until init_done=1; with init_done=1 grant=3'b010).
REQ-033 init_done=1, req[1],req[2] held, each dropping after 4 bytes -> grant order 010,100,010,100 with one IDLE cycle between.
REQ-034 Owner 1 drops req while spi_busy=1 for 9 cycles -> grant=3'b010 held 9 cycles, clears on cycle spi_busy=0.
REQ-035 IDLE_TIMEOUT=8, owner 2 holds req with no transmit -> timeout pulse after 8 idle cycles, grant clears, req[2] not regranted until toggled.
REQ-036 Non-owner pulses req_transmit[2] with data 8'hA5 while owner 1 sends 8'h2C -> spi_transmit carries only 8'h2C, req_busy[2]=1.
REQ-037 rst=0 asserted mid-burst -> grant=0, spi_transmit=0 same cycle, no clock required.
